// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port word memory with a fixed-latency request/response
// handshake. One request in flight at a time; the response is a one-cycle
// strobe after WAIT_CYCLES wait states, with no backpressure.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          enter_resp;
    logic          cur_write;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic          bad_access;
    logic [AW-1:0] word_idx;
    logic          mem_we;

    // With zero wait states the RESP-entry edge is the acceptance edge, so the
    // live request fields are used there instead of the captured copies.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        bad_access = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
        word_idx   = cur_addr[AW+1:2];
    end

    // Next-state logic: accept in IDLE, count down wait states, strobe in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response data/error and memory write enable, resolved on the RESP-entry edge.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        if (enter_resp) begin
            if (bad_access) begin
                err_d = 1'b1;
            end else if (cur_write) begin
                mem_we = !reset;
            end else begin
                rdata_d = mem[word_idx];
            end
        end
    end

    // Control and response registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: deliberately not reset so committed stores survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= cur_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: drives a zero-wait-state instance (index 0) and a
// two-wait-state instance (index 1) against a word-array reference model.
module tb_data_mem_resp;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          waits [2];
    logic [31:0] mdl [2][DEPTH];
    int          n_checks;
    int          n_pass;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present a request and return just after the edge that accepts it;
    // the request fields are then scrambled to prove they were captured.
    task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        k = 0;
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_write[s] = w;
        req_addr[s]  = a;
        req_wdata[s] = d;
        while (!req_ready[s] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(k < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_write[s] = 1'($urandom);
        req_addr[s]  = $urandom;
        req_wdata[s] = $urandom;
    endtask

    // Count cycles from acceptance to the response strobe, then check it.
    task automatic await_resp(input int s, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!resp_valid[s] && lat < 24) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(waits[s] + 1));
        check("rdata", resp_rdata[s], exp_rd);
        check("err", 32'(resp_err[s]), 32'(exp_err));
        @(negedge clk);
        check("valid_one_cycle", 32'(resp_valid[s]), 32'd0);
        check("rdata_idle", resp_rdata[s], 32'd0);
        check("err_idle", 32'(resp_err[s]), 32'd0);
    endtask

    // Reference: misaligned or beyond DEPTH words is an error with no effect.
    task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] exp_rd, output logic exp_err);
        longint unsigned widx;
        widx    = longint'(a) / 4;
        exp_err = (a % 4 != 0) || (widx >= DEPTH);
        exp_rd  = '0;
        if (!exp_err) begin
            if (w) mdl[s][widx] = d;
            else   exp_rd = mdl[s][widx];
        end
    endtask

    task automatic do_req(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] erd;
        logic        eerr;
        model(s, w, a, d, erd, eerr);
        issue(s, w, a, d);
        await_resp(s, erd, eerr);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          s;
        n_checks = 0;
        n_pass   = 0;
        waits[0] = 0;
        waits[1] = 2;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = '0;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(req_ready[i]), 32'd1);
            check("rst_valid", 32'(resp_valid[i]), 32'd0);
            check("rst_rdata", resp_rdata[i], 32'd0);
            check("rst_err", 32'(resp_err[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Store then load, two wait states.
        do_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_req(1, 1'b0, 32'h10, 32'h0);
        // Misaligned load and store, neighbour word untouched.
        do_req(1, 1'b0, 32'h6, 32'h0);
        do_req(1, 1'b1, 32'h6, 32'hCAFE_F00D);
        do_req(1, 1'b0, 32'h4, 32'h0);
        // Range boundary.
        do_req(1, 1'b1, 32'h1000, 32'h1111_2222);
        do_req(1, 1'b0, 32'hFFC, 32'h0);

        // Zero wait states, request held high: issue every second cycle.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'hA5A5_0001;
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready", 32'(req_ready[0]), 32'(i % 2 == 0));
            check("b2b_valid", 32'(resp_valid[0]), 32'(i % 2 == 1));
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        mdl[0][16] = 32'hA5A5_0001;
        do_req(0, 1'b0, 32'h40, 32'h0);

        // Reset mid-WAIT aborts the store without a response.
        issue(1, 1'b1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        check("in_wait_ready", 32'(req_ready[1]), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_ready", 32'(req_ready[1]), 32'd1);
        check("async_valid", 32'(resp_valid[1]), 32'd0);
        check("async_rdata", resp_rdata[1], 32'd0);
        check("async_err", 32'(resp_err[1]), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(1, 1'b0, 32'h20, 32'h0);
        // Store committed before reset survives it.
        do_req(1, 1'b0, 32'h10, 32'h0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 31)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
            else             a = ($urandom_range(0, 1) == 0) ? 32'hFFC : ($urandom | 32'h8000_0000);
            do_req(s, 1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request acceptance and response; range 0..15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1: initiator (CPU) presents a request.
REQ-006 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32: byte address.
REQ-008 SHALL have port req_wdata  input  32: store data.
REQ-009 SHALL have port req_ready  output  1: responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid  output  1: one-cycle response strobe.
REQ-011 SHALL have port resp_rdata  output  32: load data, valid only while resp_valid = 1.
REQ-012 SHALL have port resp_err  output  1: access error flag, valid only while resp_valid = 1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid = 1 and req_ready = 1.
REQ-015 SHALL, on acceptance, register req_write, req_addr and req_wdata; later changes on the req_* inputs SHALL NOT affect the transaction.
REQ-016 SHALL, on acceptance, go to WAIT if WAIT_CYCLES > 0, else go directly to RESP.
REQ-017 SHALL remain in WAIT for exactly WAIT_CYCLES cycles, using a 4-bit down-counter, then go to RESP.
REQ-018 SHALL assert resp_valid for exactly one cycle, in RESP, then return to IDLE.
REQ-019 SHALL place the first resp_valid cycle WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 SHALL NOT accept a new request in the RESP cycle; back-to-back issue rate is one request per WAIT_CYCLES+2 cycles.
REQ-021 SHALL have no response backpressure: the initiator must sample resp_valid when it is asserted.
REQ-022 SHALL flag a request misaligned when addr[1:0] != 0.
REQ-023 SHALL flag a request out-of-range when addr[31:2] >= DEPTH_WORDS.
REQ-024 SHALL, for a misaligned or out-of-range request, drive resp_err = 1 and resp_rdata = 0 in RESP, and SHALL NOT modify memory.
REQ-025 SHALL, for a valid store, write req_wdata to word addr[31:2] on the edge entering RESP; in RESP, resp_rdata = 0 and resp_err = 0.
REQ-026 SHALL, for a valid load, drive in RESP resp_rdata = the word at addr[31:2], including every store committed before that edge, and resp_err = 0.
REQ-027 SHALL drive resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.
REQ-028 SHALL support only full 32-bit word accesses; there are no byte enables.
REQ-029 SHALL start simulation with all memory words = 0; memory contents are not reset.

Reset
REQ-030 SHALL, while reset = 1, force state = IDLE, wait counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0 and resp_err = 0, independent of clk.
REQ-031 SHALL abort any in-flight transaction on reset, with no response issued.
REQ-032 SHALL NOT commit a store aborted by reset before its RESP-entry edge.
REQ-033 SHALL preserve stores committed before reset across reset.
REQ-034 SHALL allow acceptance on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL verify: WAIT_CYCLES=2; store 0xDEADBEEF to 0x10, then load 0x10 -> load returns resp_rdata = 0xDEADBEEF, resp_err = 0, with resp_valid 3 cycles after each acceptance.
REQ-036 SHALL verify: load 0x6 -> resp_err = 1, resp_rdata = 0; then store to 0x6 followed by load of 0x4 -> word 1 unchanged (0).
REQ-037 SHALL verify: DEPTH_WORDS=1024; store to 0x1000 -> resp_err = 1; load 0xFFC -> resp_err = 0, rdata = 0.
REQ-038 SHALL verify: WAIT_CYCLES=0; back-to-back stores with req_valid held high -> req_ready pattern 1,0,1,0 and resp_valid on every second cycle.
REQ-039 SHALL verify: store 0x12345678 to 0x20, assert reset asynchronously (mid-cycle) during WAIT -> resp_valid stays 0, outputs go to reset values immediately, and a later load of 0x20 returns 0.
REQ-040 SHALL verify: change req_addr and req_wdata after acceptance, during WAIT -> the response and memory reflect the originally accepted values.
